// File: rtl/button_debouncer_pkg.sv
//==============================================================================
// Module      : button_debouncer_pkg
// Description : Shared state encoding and cycle-count helper for the debouncer.
// Revision    : 1.0
//==============================================================================
`default_nettype none

package button_debouncer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_RELEASED      = 2'd0;
    localparam state_t ST_CHECK_PRESS   = 2'd1;
    localparam state_t ST_PRESSED       = 2'd2;
    localparam state_t ST_CHECK_RELEASE = 2'd3;

    // Number of clk cycles spanning the given time for a clock given in kHz.
    function automatic int unsigned cycles_for_ms(input int unsigned khz,
                                                  input int unsigned ms);
        return khz * ms;
    endfunction

endpackage

`default_nettype wire

// File: rtl/button_debouncer_sync_2ff.sv
//==============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a single asynchronous bit, reset to 0.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end

    assign q = r_s2;

endmodule

`default_nettype wire

// File: rtl/button_debouncer.sv
//==============================================================================
// Module      : button_debouncer
// Description : Debounces a raw button into a clean level plus press/release
//               pulses. Define BUTTON_DEBOUNCER_LONG_PRESS_EN to add btn_long.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int unsigned CLK_FREQ_KHz  = 50000,
    parameter int unsigned DEBOUNCE_MS   = 10,
    parameter int unsigned LONG_PRESS_MS = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    ,
    output logic btn_long
`endif
);

    localparam int unsigned c_STABLE_CNT = cycles_for_ms(CLK_FREQ_KHz, DEBOUNCE_MS);
    localparam int unsigned c_CNT_W      = $clog2(c_STABLE_CNT);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(c_STABLE_CNT - 1);

    // A one-cycle window cannot be debounced and a zero hold time is meaningless.
    if (c_STABLE_CNT < 2 || LONG_PRESS_MS == 0) begin : g_cfg_check
        $error("button_debouncer: STABLE_CNT must be >= 2 and LONG_PRESS_MS > 0");
    end

    logic                 w_sync;
    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_level;
    logic                 r_press;
    logic                 r_release;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (w_sync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_RELEASED;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (r_state)
                ST_RELEASED: begin
                    r_cnt <= '0;
                    if (w_sync) r_state <= ST_CHECK_PRESS;
                end
                ST_CHECK_PRESS: begin
                    if (!w_sync) begin
                        r_state <= ST_RELEASED;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_CNT_MAX) begin
                        r_state <= ST_PRESSED;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                ST_PRESSED: begin
                    r_cnt <= '0;
                    if (!w_sync) r_state <= ST_CHECK_RELEASE;
                end
                ST_CHECK_RELEASE: begin
                    if (w_sync) begin
                        r_state <= ST_PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_CNT_MAX) begin
                        r_state   <= ST_RELEASED;
                        r_cnt     <= '0;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_RELEASED;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam int unsigned c_LONG_CNT = cycles_for_ms(CLK_FREQ_KHz, LONG_PRESS_MS);
    localparam int unsigned c_HOLD_W   = $clog2(c_LONG_CNT + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(c_LONG_CNT);

    logic                  w_accept_press;
    logic [c_HOLD_W-1:0]   r_hold;
    logic                  r_long;

    assign w_accept_press = (r_state == ST_CHECK_PRESS) && w_sync && (r_cnt == c_CNT_MAX);

    // Saturation at LONG_CNT is what limits btn_long to one pulse per press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
            r_long <= 1'b0;
        end else begin
            r_long <= 1'b0;
            if (w_accept_press) begin
                r_hold <= '0;
            end else if ((r_state == ST_PRESSED || r_state == ST_CHECK_RELEASE) &&
                         (r_hold != c_HOLD_MAX)) begin
                r_hold <= r_hold + c_HOLD_W'(1);
                if (r_hold == c_HOLD_MAX - c_HOLD_W'(1)) r_long <= 1'b1;
            end
        end
    end

    assign btn_long = r_long;
`endif

endmodule

`default_nettype wire

// File: tb/tb_button_debouncer.sv
//==============================================================================
// Module      : tb_button_debouncer
// Description : Scoreboard bench for button_debouncer with a run-length model.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module tb_button_debouncer;

    localparam int unsigned KHZ    = 1;
    localparam int unsigned DMS    = 4;
    localparam int unsigned LMS    = 10;
    localparam int unsigned STABLE = KHZ * DMS;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic btn_in = 1'b0;
    logic btn_level;
    logic btn_press;
    logic btn_release;
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    logic btn_long;
`endif

    button_debouncer #(
        .CLK_FREQ_KHz  (KHZ),
        .DEBOUNCE_MS   (DMS),
        .LONG_PRESS_MS (LMS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
        ,
        .btn_long    (btn_long)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit level;
        bit press;
        bit rel;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: btn_in reaches the decision point two edges late; a new
    // level is accepted once it has been seen there STABLE+1 edges in a row.
    bit m_p1, m_p2, m_level;
    int m_run;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void model_step(input bit r, input bit b);
        exp_t e;
        bit   seen;
        e.level = 1'b0;
        e.press = 1'b0;
        e.rel   = 1'b0;
        if (r) begin
            m_p1 = 1'b0; m_p2 = 1'b0; m_level = 1'b0; m_run = 0;
        end else begin
            seen = m_p2;
            m_p2 = m_p1;
            m_p1 = b;
            if (seen != m_level) begin
                m_run = m_run + 1;
                if (m_run == int'(STABLE) + 1) begin
                    m_level = seen;
                    m_run   = 0;
                    if (seen) e.press = 1'b1;
                    else      e.rel   = 1'b1;
                end
            end else begin
                m_run = 0;
            end
        end
        e.level = m_level;
        exp_q.push_back(e);
    endfunction

    function automatic void chk(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, expv);
        end
    endfunction

    // One edge per call: inputs change on the falling edge, model predicts the next rise.
    task automatic drive(input bit b, input int n, input bit r);
        repeat (n) begin
            @(negedge clk);
            btn_in = b;
            rst    = r;
            model_step(r, b);
        end
    endtask

    exp_t mon_e;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("btn_level", btn_level, mon_e.level);
                chk("btn_press", btn_press, mon_e.press);
                chk("btn_release", btn_release, mon_e.rel);
                chk("press_release_exclusive", btn_press & btn_release, 1'b0);
            end
        end
    end

    int lvl_i;
    int len_i;
    bit rst_i;
    initial begin
        m_p1 = 1'b0; m_p2 = 1'b0; m_level = 1'b0; m_run = 0;
        drive(1'b0, 3, 1'b1);
        // clean press then clean release
        drive(1'b0, 5, 1'b0);
        drive(1'b1, 12, 1'b0);
        drive(1'b0, 12, 1'b0);
        // bounce: 3 high, 2 low, 2 high, then low
        drive(1'b1, 3, 1'b0);
        drive(1'b0, 2, 1'b0);
        drive(1'b1, 2, 1'b0);
        drive(1'b0, 10, 1'b0);
        // pulse of exactly STABLE cycles is rejected, STABLE+1 is accepted
        drive(1'b1, STABLE, 1'b0);
        drive(1'b0, 8, 1'b0);
        drive(1'b1, STABLE + 1, 1'b0);
        drive(1'b0, 12, 1'b0);
        // reset in the middle of a pending press, button held through it
        drive(1'b1, 4, 1'b0);
        drive(1'b1, 1, 1'b1);
        drive(1'b1, 12, 1'b0);
        drive(1'b0, 12, 1'b0);
        // back-to-back press and release
        drive(1'b1, 7, 1'b0);
        drive(1'b0, 5, 1'b0);
        drive(1'b1, 1, 1'b0);
        drive(1'b0, 10, 1'b0);
        repeat (300) begin
            lvl_i = $urandom_range(0, 1);
            len_i = $urandom_range(1, 9);
            rst_i = ($urandom_range(0, 40) == 0);
            drive(lvl_i[0], len_i, rst_i);
        end
        drive(1'b0, 12, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
